// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial ripple adder computing {cout,sum} = a + b + cin, one
//            full-adder bit per clock, LSB first, with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW     = $clog2(WIDTH + 1);
    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_BUSY = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic w_s;
    logic w_maj;

    assign w_s   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign w_maj = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                carry_d           = w_maj;
                res_d             = res_q >> 1;
                res_d[WIDTH-1]    = w_s;
                a_sr_d            = a_sr_q >> 1;
                b_sr_d            = b_sr_q >> 1;
                cnt_d             = cnt_q + CW'(1);
                // Output registers only update here, so sum/cout keep the last
                // result through IDLE and the next operation's BUSY phase.
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                    sum_d   = res_d;
                    cout_d  = w_maj;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, busy2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start8(input logic [7:0] a_v, input logic [7:0] b_v, input logic c_v);
        a8 = a_v; b8 = b_v; cin8 = c_v; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
    endtask

    // Counts cycles after the capture edge until out_valid; 99 means timeout.
    task automatic wait_done8(output int lat, output int bc);
        lat = 99; bc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (busy8) bc++;
            if (out_valid8) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release8();
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
    endtask

    initial begin
        int lat, bc, n;
        logic [2:0] exp2;
        rst = 1'b0;
        in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        in_valid2 = 0; out_ready2 = 0; a2 = '0; b2 = '0; cin2 = 0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_sum", sum8, 8'h00);
        chk("rst_cout", cout8, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // zeros: latency and busy duration
        start8(8'h00, 8'h00, 1'b0);
        wait_done8(lat, bc);
        chk("zero_latency", lat, 9);
        chk("zero_busy_cycles", bc, 8);
        chk("zero_sum", sum8, 8'h00);
        chk("zero_cout", cout8, 0);
        release8();
        @(negedge clk);
        chk("zero_back_idle", in_ready8, 1);
        chk("zero_ov_low", out_valid8, 0);

        // carry ripple through all bits
        tick();
        start8(8'hFF, 8'h01, 1'b0);
        wait_done8(lat, bc);
        chk("ff01_latency", lat, 9);
        chk("ff01_sum", sum8, 8'h00);
        chk("ff01_cout", cout8, 1);
        release8();
        @(negedge clk);
        chk("ff01_retain_sum", sum8, 8'h00);
        chk("ff01_retain_cout", cout8, 1);

        tick();
        start8(8'h3C, 8'h42, 1'b1);
        wait_done8(lat, bc);
        chk("3c42_sum", sum8, 8'h7F);
        chk("3c42_cout", cout8, 0);
        release8();

        // backpressure with in_valid pulsing during DONE
        tick();
        start8(8'h96, 8'h81, 1'b0);
        wait_done8(lat, bc);
        chk("bp_first_sum", sum8, 8'h17);
        for (int i = 0; i < 5; i++) begin
            a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; in_valid8 = (i % 2 == 0);
            tick();
            @(negedge clk);
            chk("bp_out_valid", out_valid8, 1);
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_sum", sum8, 8'h17);
            chk("bp_cout", cout8, 1);
        end
        // in_valid held high across the DONE->IDLE edge must not be taken there
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        in_valid8 = 1'b0;
        @(negedge clk);
        chk("bp_idle_ready", in_ready8, 1);
        chk("bp_no_capture", busy8, 0);
        chk("bp_sum_kept", sum8, 8'h17);

        // operands change during BUSY
        tick();
        start8(8'h12, 8'h34, 1'b0);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        wait_done8(lat, bc);
        chk("chg_sum", sum8, 8'h46);
        chk("chg_cout", cout8, 0);
        release8();

        // reset during 4th BUSY cycle
        tick();
        start8(8'h55, 8'h55, 1'b0);
        tick(); tick(); tick();
        chk("abort_in_busy", busy8, 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid8, 0);
        chk("abort_in_ready", in_ready8, 1);
        chk("abort_sum", sum8, 8'h00);
        chk("abort_busy", busy8, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();
        start8(8'h10, 8'h20, 1'b0);
        wait_done8(lat, bc);
        chk("post_rst_latency", lat, 9);
        chk("post_rst_sum", sum8, 8'h30);
        chk("post_rst_cout", cout8, 0);
        release8();

        // WIDTH=2 exhaustive with random out_ready
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            a2 = v[1:0]; b2 = v[3:2]; cin2 = v[4];
            exp2 = 3'(v[1:0]) + 3'(v[3:2]) + 3'(v[4]);
            in_valid2 = 1'b1;
            tick();
            in_valid2 = 1'b0;
            out_ready2 = 1'($urandom_range(0, 1));
            lat = 99;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (out_valid2) begin
                    lat = k;
                    break;
                end
            end
            chk("w2_latency", lat, 3);
            chk("w2_result", {cout2, sum2}, exp2);
            n = out_ready2 ? 0 : $urandom_range(0, 2);
            repeat (n) tick();
            out_ready2 = 1'b1;
            tick();
            out_ready2 = 1'b0;
        end
        @(negedge clk);
        chk("w2_final_idle", in_ready2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
